// File: rtl/colour_pkg.sv
// Shared constants and types for the colour region detector: class indices,
// region encodings, pixel geometry and the frame FSM state type.
package colour_pkg;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned SUM_W  = CHAN_W + 1;

    localparam int unsigned CLS_RED   = 0;
    localparam int unsigned CLS_GREEN = 1;
    localparam int unsigned CLS_BLUE  = 2;
    localparam int unsigned CLS_WHITE = 3;

    localparam logic [1:0] REG_NONE   = 2'd0;
    localparam logic [1:0] REG_LEFT   = 2'd1;
    localparam logic [1:0] REG_CENTRE = 2'd2;
    localparam logic [1:0] REG_RIGHT  = 2'd3;

    localparam logic [CHAN_W-1:0] WHITE_MIN = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/colour_classifier.sv
// Combinational RGB444 colour classifier: one match bit per colour class.
module colour_classifier
    import colour_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned MARGIN = 2
) (
    input  logic [PIX_W-1:0]  pixel_i,
    output logic [NUM_CH-1:0] match_o
);

    logic [SUM_W-1:0] r_c, g_c, b_c;
    logic [SUM_W-1:0] r_lim_c, g_lim_c, b_lim_c;

    // Channels widened by one bit so that adding the margin cannot wrap.
    always_comb begin
        r_c     = {1'b0, pixel_i[11:8]};
        g_c     = {1'b0, pixel_i[7:4]};
        b_c     = {1'b0, pixel_i[3:0]};
        r_lim_c = r_c + SUM_W'(MARGIN);
        g_lim_c = g_c + SUM_W'(MARGIN);
        b_lim_c = b_c + SUM_W'(MARGIN);
        match_o = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            case (i)
                CLS_RED:   match_o[i] = (r_c > g_lim_c) && (r_c > b_lim_c);
                CLS_GREEN: match_o[i] = (g_c > r_lim_c) && (g_c > b_lim_c);
                CLS_BLUE:  match_o[i] = (b_c > r_lim_c) && (b_c > g_lim_c);
                CLS_WHITE: match_o[i] = (pixel_i[11:8] >= WHITE_MIN) &&
                                        (pixel_i[7:4]  >= WHITE_MIN) &&
                                        (pixel_i[3:0]  >= WHITE_MIN);
                default:   match_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/colour_region_detect.sv
// Per-frame colour class counter with left/centre/right region detection.
// Pipeline: stage 1 registers classification, stage 2 accumulates, LATCH publishes.
module colour_region_detect
    import colour_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned CNT_W  = 17,
    parameter int unsigned MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sop,
    input  logic                    eop,
    input  logic                    pixel_valid,
    input  logic [PIX_W-1:0]        pixel,
    input  logic                    mode,
    input  logic [NUM_CH*CNT_W-1:0] threshold,
    output logic [NUM_CH-1:0]       colour_flag,
    output logic [NUM_CH*2-1:0]     region,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic                    frame_done
);

    localparam int unsigned COL_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned LEFT_END   = IMG_W / 3;
    localparam int unsigned CENTRE_END = (2 * IMG_W) / 3;

    if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << CNT_W) - 64'd1) begin : g_cnt_w_check
        $error("CNT_W cannot hold IMG_W*IMG_H");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Ties resolve centre first, then left, then right.
    function automatic logic [1:0] best_third(input logic [CNT_W-1:0] l,
                                              input logic [CNT_W-1:0] c,
                                              input logic [CNT_W-1:0] r);
        if (c >= l && c >= r) begin
            return REG_CENTRE;
        end else if (l >= r) begin
            return REG_LEFT;
        end
        return REG_RIGHT;
    endfunction

    // ---------------- stage 0: column tracking and classification
    logic [COL_W-1:0]  col_q, col_d, pix_col_c;
    logic [1:0]        pix_third_c;
    logic [NUM_CH-1:0] pix_match_c;

    colour_classifier #(
        .NUM_CH (NUM_CH),
        .MARGIN (MARGIN)
    ) u_classifier (
        .pixel_i (pixel),
        .match_o (pix_match_c)
    );

    always_comb begin
        pix_col_c = sop ? '0 : col_q;
        col_d     = col_q;
        if (pixel_valid) begin
            col_d = (pix_col_c == COL_W'(IMG_W - 1)) ? '0 : pix_col_c + 1'b1;
        end
        if (pix_col_c < COL_W'(LEFT_END)) begin
            pix_third_c = 2'd0;
        end else if (pix_col_c < COL_W'(CENTRE_END)) begin
            pix_third_c = 2'd1;
        end else begin
            pix_third_c = 2'd2;
        end
    end

    // ---------------- stage 1 registers
    logic              s1_valid_q, s1_sop_q, s1_eop_q;
    logic [1:0]        s1_third_q;
    logic [NUM_CH-1:0] s1_match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_third_q <= 2'd0;
            s1_match_q <= '0;
        end else begin
            col_q      <= col_d;
            s1_valid_q <= pixel_valid;
            s1_sop_q   <= pixel_valid & sop;
            s1_eop_q   <= pixel_valid & eop;
            s1_third_q <= pix_third_c;
            s1_match_q <= pix_match_c;
        end
    end

    // ---------------- frame FSM
    state_e state_q, state_d;
    logic   clear_c, accum_c, latch_c;

    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        accum_c = 1'b0;
        latch_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (s1_valid_q && s1_sop_q) begin
                    clear_c = 1'b1;
                    accum_c = 1'b1;
                    state_d = s1_eop_q ? LATCH : ACCUM;
                end
            end
            ACCUM: begin
                if (s1_valid_q) begin
                    accum_c = 1'b1;
                    clear_c = s1_sop_q;
                    if (s1_eop_q) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                latch_c = 1'b1;
                state_d = IDLE;
                // A sop arriving right behind the eop must not be lost.
                if (s1_valid_q && s1_sop_q) begin
                    clear_c = 1'b1;
                    accum_c = 1'b1;
                    state_d = s1_eop_q ? LATCH : ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- stage 2 accumulators: per class total and per third
    logic [CNT_W-1:0] tot_q [NUM_CH];
    logic [CNT_W-1:0] tot_d [NUM_CH];
    logic [CNT_W-1:0] thr_q [NUM_CH][3];
    logic [CNT_W-1:0] thr_d [NUM_CH][3];

    always_comb begin
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            tot_d[ch] = clear_c ? '0 : tot_q[ch];
            for (int t = 0; t < 3; t++) begin
                thr_d[ch][t] = clear_c ? '0 : thr_q[ch][t];
            end
            if (accum_c && s1_match_q[ch]) begin
                tot_d[ch] = sat_inc(tot_d[ch]);
                for (int t = 0; t < 3; t++) begin
                    if (s1_third_q == 2'(t)) begin
                        thr_d[ch][t] = sat_inc(thr_d[ch][t]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                tot_q[ch] <= '0;
                for (int t = 0; t < 3; t++) begin
                    thr_q[ch][t] <= '0;
                end
            end
        end else begin
            tot_q <= tot_d;
            thr_q <= thr_d;
        end
    end

    // ---------------- result registers, loaded only in LATCH
    logic [NUM_CH*CNT_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0]       flag_q, flag_d;
    logic [NUM_CH*2-1:0]     region_q, region_d;
    logic                    done_q, done_d;

    always_comb begin
        count_d  = count_q;
        flag_d   = flag_q;
        region_d = region_q;
        done_d   = 1'b0;
        if (latch_c) begin
            done_d = 1'b1;
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                count_d[ch*CNT_W +: CNT_W] = tot_q[ch];
                flag_d[ch] = (tot_q[ch] >= threshold[ch*CNT_W +: CNT_W]);
                if (!flag_d[ch]) begin
                    region_d[ch*2 +: 2] = REG_NONE;
                end else if (!mode) begin
                    region_d[ch*2 +: 2] = REG_CENTRE;
                end else begin
                    region_d[ch*2 +: 2] = best_third(thr_q[ch][0], thr_q[ch][1], thr_q[ch][2]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            flag_q   <= '0;
            region_q <= '0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            flag_q   <= flag_d;
            region_q <= region_d;
            done_q   <= done_d;
        end
    end

    assign count       = count_q;
    assign colour_flag = flag_q;
    assign region      = region_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_colour_region_detect.sv
// Directed bench for colour_region_detect on a reduced 32x10 frame with 9-bit counters.
module tb_colour_region_detect;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned IMG_W  = 32;
    localparam int unsigned IMG_H  = 10;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned MARGIN = 2;
    localparam int unsigned FRAME  = IMG_W * IMG_H;
    localparam int unsigned VW     = NUM_CH * CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              sop, eop, pixel_valid, mode;
    logic [11:0]       pixel;
    logic [VW-1:0]     threshold;
    logic [NUM_CH-1:0] colour_flag;
    logic [NUM_CH*2-1:0] region;
    logic [VW-1:0]     count;
    logic              frame_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    logic [VW-1:0] fd_snap [$];

    colour_region_detect #(
        .NUM_CH (NUM_CH),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CNT_W  (CNT_W),
        .MARGIN (MARGIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sop         (sop),
        .eop         (eop),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .mode        (mode),
        .threshold   (threshold),
        .colour_flag (colour_flag),
        .region      (region),
        .count       (count),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Records every frame_done pulse and the result published with it.
    always @(posedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_snap.push_back(count);
        end
    end

    function automatic logic [VW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
    endfunction

    function automatic logic [11:0] pix_for(input int pat, input int col);
        case (pat)
            0: return 12'hF00;
            1: return (col >= 22) ? 12'hF00 : 12'h000;
            2: return 12'h00F;
            3: return (col >= 5 && col <= 14) ? 12'hF00 : 12'h000;
            4: return (col < 5 || col >= 27) ? 12'hF00 : 12'h000;
            5: begin
                case (col % 4)
                    0: return 12'hF00;
                    1: return 12'h0F0;
                    2: return 12'h00F;
                    default: return 12'hFFF;
                endcase
            end
            default: return 12'h000;
        endcase
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic [11:0] p);
        @(negedge clk);
        pixel_valid = v;
        sop         = s;
        eop         = e;
        pixel       = p;
    endtask

    task automatic send_frame(input int n, input int pat, input bit gaps, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) drive(1'b0, 1'b0, 1'b0, 12'hFFF);
            drive(1'b1, i == 0, with_eop && (i == n - 1), pix_for(pat, i % IMG_W));
        end
    endtask

    // Idles for 12 cycles; lat = cycles from the last driven pixel to frame_done, -1 if none.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b0, 1'b0, 12'h000);
            if (frame_done && lat < 0) lat = k;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; sop = 1'b0; eop = 1'b0; pixel_valid = 1'b0; pixel = '0;
        mode = 1'b0; threshold = '0;
        repeat (3) @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %h exp 0", count); end
        checks++; if (colour_flag !== '0) begin errors++; $display("FAIL reset_flag got %b exp 0", colour_flag); end
        checks++; if (region !== '0) begin errors++; $display("FAIL reset_region got %b exp 0", region); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
        reset = 1'b0;
    endtask

    task automatic test_whole_frame;
        int lat;
        mode = 1'b0;
        threshold = pack4(320, 320, 320, 320);
        send_frame(FRAME, 0, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL whole_latency got %0d exp 3", lat); end
        checks++; if (count !== pack4(320, 0, 0, 0)) begin errors++; $display("FAIL whole_count got %h exp %h", count, pack4(320, 0, 0, 0)); end
        checks++; if (colour_flag !== 4'b0001) begin errors++; $display("FAIL whole_flag got %b exp 0001", colour_flag); end
        checks++; if (region !== 8'b00_00_00_10) begin errors++; $display("FAIL whole_region got %b exp 00000010", region); end
        repeat (5) drive(1'b0, 1'b0, 1'b1, 12'h0F0);
        checks++; if (count !== pack4(320, 0, 0, 0)) begin errors++; $display("FAIL hold_count got %h exp %h", count, pack4(320, 0, 0, 0)); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL hold_done got %b exp 0", frame_done); end
        threshold = pack4(321, 320, 320, 320);
        send_frame(FRAME, 0, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (colour_flag !== 4'b0000) begin errors++; $display("FAIL thr_boundary_flag got %b exp 0000", colour_flag); end
        checks++; if (region !== 8'b0) begin errors++; $display("FAIL thr_boundary_region got %b exp 0", region); end
    endtask

    task automatic test_classify;
        logic [11:0] px  [8] = '{12'h880, 12'hFFF, 12'h300, 12'h200, 12'h0C0, 12'h00D, 12'hCCB, 12'hCCC};
        logic [3:0]  exb [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
        int lat;
        logic [VW-1:0] exp_cnt;
        mode = 1'b0;
        threshold = pack4(1, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, px[i]);
            wait_done(lat);
            exp_cnt = pack4(int'(exb[i][0]), int'(exb[i][1]), int'(exb[i][2]), int'(exb[i][3]));
            checks++; if (lat !== 3) begin errors++; $display("FAIL classify_latency[%h] got %0d exp 3", px[i], lat); end
            checks++; if (count !== exp_cnt) begin errors++; $display("FAIL classify_count[%h] got %h exp %h", px[i], count, exp_cnt); end
            checks++; if (colour_flag !== exb[i]) begin errors++; $display("FAIL classify_flag[%h] got %b exp %b", px[i], colour_flag, exb[i]); end
        end
    endtask

    task automatic test_region;
        int pats [4] = '{1, 3, 4, 1};
        int thr0 [4] = '{50, 100, 100, 101};
        logic [1:0] exr [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        int lat;
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            threshold = pack4(thr0[i], 500, 500, 500);
            send_frame(FRAME, pats[i], 1'b0, 1'b1);
            wait_done(lat);
            checks++; if (count !== pack4(100, 0, 0, 0)) begin errors++; $display("FAIL region_count[%0d] got %h exp %h", i, count, pack4(100, 0, 0, 0)); end
            checks++; if (region !== {6'b0, exr[i]}) begin errors++; $display("FAIL region_sel[%0d] got %b exp %b", i, region, {6'b0, exr[i]}); end
        end
    endtask

    task automatic test_restart;
        int lat;
        int fd0;
        mode = 1'b1;
        threshold = pack4(320, 320, 320, 320);
        fd0 = fd_cnt;
        send_frame(100, 0, 1'b0, 1'b0);
        send_frame(FRAME, 2, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL restart_pulses got %0d exp 1", fd_cnt - fd0); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL restart_latency got %0d exp 3", lat); end
        checks++; if (count !== pack4(0, 0, 320, 0)) begin errors++; $display("FAIL restart_count got %h exp %h", count, pack4(0, 0, 320, 0)); end
        checks++; if (region !== 8'b00_10_00_00) begin errors++; $display("FAIL restart_region got %b exp 00100000", region); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int fd0;
        send_frame(150, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL midreset_count got %h exp 0", count); end
        checks++; if (colour_flag !== '0) begin errors++; $display("FAIL midreset_flag got %b exp 0", colour_flag); end
        checks++; if (region !== '0) begin errors++; $display("FAIL midreset_region got %b exp 0", region); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", frame_done); end
        @(negedge clk);
        reset = 1'b0;
        mode = 1'b0;
        threshold = pack4(320, 320, 320, 320);
        fd0 = fd_cnt;
        drive(1'b1, 1'b0, 1'b0, 12'hF00);
        drive(1'b1, 1'b0, 1'b1, 12'hF00);
        wait_done(lat);
        checks++; if (lat !== -1) begin errors++; $display("FAIL idle_eop_done got %0d exp -1", lat); end
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL idle_eop_pulses got %0d exp 0", fd_cnt - fd0); end
        send_frame(FRAME, 0, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL postreset_pulses got %0d exp 1", fd_cnt - fd0); end
        checks++; if (count !== pack4(320, 0, 0, 0)) begin errors++; $display("FAIL postreset_count got %h exp %h", count, pack4(320, 0, 0, 0)); end
    endtask

    task automatic test_gaps;
        int lat;
        mode = 1'b0;
        threshold = pack4(80, 80, 80, 80);
        send_frame(FRAME, 5, 1'b1, 1'b1);
        wait_done(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL gaps_latency got %0d exp 3", lat); end
        checks++; if (count !== pack4(80, 80, 80, 80)) begin errors++; $display("FAIL gaps_count got %h exp %h", count, pack4(80, 80, 80, 80)); end
        checks++; if (colour_flag !== 4'b1111) begin errors++; $display("FAIL gaps_flag got %b exp 1111", colour_flag); end
        checks++; if (region !== 8'b10_10_10_10) begin errors++; $display("FAIL gaps_region got %b exp 10101010", region); end
        send_frame(FRAME, 5, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (count !== pack4(80, 80, 80, 80)) begin errors++; $display("FAIL nogaps_count got %h exp %h", count, pack4(80, 80, 80, 80)); end
    endtask

    task automatic test_saturation;
        int lat;
        mode = 1'b0;
        threshold = pack4(511, 320, 320, 320);
        send_frame(600, 0, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (count !== pack4(511, 0, 0, 0)) begin errors++; $display("FAIL sat_count got %h exp %h", count, pack4(511, 0, 0, 0)); end
        checks++; if (colour_flag !== 4'b0001) begin errors++; $display("FAIL sat_flag got %b exp 0001", colour_flag); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int n0;
        mode = 1'b0;
        threshold = pack4(320, 320, 320, 320);
        n0 = fd_snap.size();
        send_frame(FRAME, 0, 1'b0, 1'b1);
        send_frame(FRAME, 2, 1'b0, 1'b1);
        wait_done(lat);
        checks++; if (fd_snap.size() - n0 !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", fd_snap.size() - n0); end
        if (fd_snap.size() > n0) begin
            checks++; if (fd_snap[n0] !== pack4(320, 0, 0, 0)) begin errors++; $display("FAIL b2b_first got %h exp %h", fd_snap[n0], pack4(320, 0, 0, 0)); end
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d exp 3", lat); end
        checks++; if (count !== pack4(0, 0, 320, 0)) begin errors++; $display("FAIL b2b_second got %h exp %h", count, pack4(0, 0, 320, 0)); end
    endtask

    initial begin
        test_reset();
        test_whole_frame();
        test_classify();
        test_region();
        test_restart();
        test_reset_mid();
        test_gaps();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/colour_region_detect.md
COLOUR_REGION_DETECT -- requirements
Module: colour_region_detect

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, giving the number of colour classes (1..4).
REQ-002 SHALL have parameter IMG_W, default 320, giving the pixels per line.
REQ-003 SHALL have parameter IMG_H, default 240, giving the lines per frame.
REQ-004 SHALL have parameter CNT_W, default 17, giving the counter width; it must hold IMG_W*IMG_H.
REQ-005 SHALL have parameter MARGIN, default 2, giving the nibble dominance margin.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port sop, input, 1 bit: start of frame, qualified by pixel_valid, coincident with pixel 0.
REQ-009 SHALL have port eop, input, 1 bit: end of frame, qualified by pixel_valid, coincident with the last pixel.
REQ-010 SHALL have port pixel_valid, input, 1 bit: pixel qualifier.
REQ-011 SHALL have port pixel, input, 12 bits: RGB444 as {R[11:8],G[7:4],B[3:0]}.
REQ-012 SHALL have port mode, input, 1 bit: 0 = whole-frame count, 1 = left/centre/right region.
REQ-013 SHALL have port threshold, input, NUM_CH x CNT_W: per-class pixel-count threshold.
REQ-014 SHALL have port colour_flag, output, NUM_CH bits: class count >= threshold.
REQ-015 SHALL have port region, output, NUM_CH x 2 bits: 0 none, 1 left, 2 centre, 3 right.
REQ-016 SHALL have port count, output, NUM_CH x CNT_W: last-frame total per class.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse when results update.

Function
REQ-018 SHALL classify with these rules: class 0 red: R > G+MARGIN and R > B+MARGIN; class 1 green and class 2 blue are analogous; class 3 white: R, G and B all >= 12. Sums SHALL be 5-bit, so there is no wrap.
REQ-019 SHALL register the classification one cycle after an accepted pixel (stage 1) and accumulate in stage 2.
REQ-020 SHALL use FSM states IDLE, ACCUM and LATCH.
REQ-021 SHALL move IDLE->ACCUM on sop&pixel_valid, clearing all accumulators, with that pixel counted as column 0.
REQ-022 SHALL, in ACCUM, increment the column counter per valid pixel and wrap to 0 after IMG_W-1.
REQ-023 SHALL take pixel columns [0, IMG_W/3) as left, [IMG_W/3, 2*IMG_W/3) as centre, and the rest as right.
REQ-024 SHALL increment, per class, a total counter and the counter for the current third when the class matches.
REQ-025 SHALL saturate all counters at 2^CNT_W-1, with no wrap.
REQ-026 SHALL move ACCUM->LATCH on eop&pixel_valid, after the eop pixel is accumulated.
REQ-027 SHALL, in LATCH, update count, colour_flag and region, pulse frame_done, then return to IDLE; eop-pixel-to-frame_done latency is 3 cycles.
REQ-028 SHALL, in mode 0, set region to 0 when the flag is clear, otherwise to 2.
REQ-029 SHALL, in mode 1 with the flag set, set region to the third with the largest count, resolving ties centre > left > right.
REQ-030 SHALL sample mode and threshold in LATCH only.
REQ-031 SHALL, on sop during ACCUM, discard the partial frame, restart the accumulation and produce no frame_done.
REQ-032 SHALL ignore eop while in IDLE.
REQ-033 SHALL, on simultaneous sop and eop, treat the input as a one-pixel frame.
REQ-034 SHALL hold all outputs between frame_done pulses.
REQ-035 SHALL ignore pixel_valid=0 cycles, including in the column count.

Reset
REQ-036 SHALL, on reset assertion, immediately force the FSM to IDLE and colour_flag, region, count, frame_done and all accumulators to 0.
REQ-037 SHALL, on reset mid-frame, lose the frame, with the first result following the next sop..eop.

Structure
REQ-038 SHALL place the class index constants (CLS_RED=0, CLS_GREEN, CLS_BLUE, CLS_WHITE), the region encodings, and the FSM state typedef in package colour_pkg.
REQ-039 SHALL implement the per-pixel classification as sub-module colour_classifier (combinational, pixel in, NUM_CH match bits out), with instantiation once per class vector.

Verification
REQ-040 SHALL cover this scenario: 320x240 frame all 12'hF00, threshold0=76800 -> colour_flag[0]=1, count0=76800, count1=count2=0, frame_done 3 cycles after eop.
REQ-041 SHALL cover this scenario: mode=1, red only in columns 220..319 of every line, threshold0=1000 -> region0=3, count0=24000.
REQ-042 SHALL cover this scenario: pixel 12'h880 (R=G) -> no class 0 or 1 match; 12'hFFF -> class 3 only.
REQ-043 SHALL cover this scenario: sop at pixel 500 of a frame, then a full blue frame -> one frame_done, count2=76800.
REQ-044 SHALL cover this scenario: reset asserted mid-ACCUM -> outputs 0 at once, no frame_done until the next complete frame.
REQ-045 SHALL cover this scenario: pixel_valid toggled 50% through a frame -> counts identical to the gap-free frame.
